// File: rtl/key_pulse_pkg.sv
// rtl/key_pulse_pkg.sv - shared mode and repeat-state types for the key front end
package key_pulse_pkg;

  typedef enum logic [1:0] {
    MODE_RISE   = 2'b00,
    MODE_FALL   = 2'b01,
    MODE_BOTH   = 2'b10,
    MODE_REPEAT = 2'b11
  } pulse_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD   = 2'b01,
    REPEAT = 2'b10
  } rep_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_pulse_channel.sv
// rtl/key_pulse_channel.sv - one key: synchroniser, debounce, edge detect, hold-repeat
module key_pulse_channel
  import key_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key,
  input  pulse_mode_e mode,
  output logic        level,
  output logic        pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = max_int(HOLD_CYCLES, REPEAT_CYCLES);
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_CYCLES - 1);
  localparam logic [RP_W-1:0] REP_LAST  = RP_W'(REPEAT_CYCLES - 1);

  logic            s1_q, s2_q;
  logic            stable_q, stable_d;
  logic            stable_dly_q;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
  rep_state_e      state_q, state_d;
  logic            pulse_q, pulse_d;

  logic rise, fall, repeat_en, rep_fire;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    // any sample agreeing with the accepted level restarts the stability count
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  assign rise      = stable_q & ~stable_dly_q;
  assign fall      = ~stable_q & stable_dly_q;
  assign repeat_en = stable_q && (mode == MODE_REPEAT);

  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    rep_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise && (mode == MODE_REPEAT)) begin
          state_d   = HOLD;
          rep_cnt_d = '0;
        end
      end
      HOLD: begin
        if (!repeat_en) begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == HOLD_LAST) begin
          rep_fire  = 1'b1;
          state_d   = REPEAT;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RP_W'(1);
        end
      end
      REPEAT: begin
        if (!repeat_en) begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == REP_LAST) begin
          rep_fire  = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RP_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        rep_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pulse_d = rep_fire;
    if (rise && (mode != MODE_FALL)) begin
      pulse_d = 1'b1;
    end
    if (fall && ((mode == MODE_FALL) || (mode == MODE_BOTH))) begin
      pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      rep_cnt_q    <= '0;
      state_q      <= IDLE;
      pulse_q      <= 1'b0;
    end else begin
      s1_q         <= key;
      s2_q         <= s1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      state_q      <= state_d;
      pulse_q      <= pulse_d;
    end
  end

  assign level = stable_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/key_pulse_detector.sv
// rtl/key_pulse_detector.sv - N-channel debounced key front end with event pulses
module key_pulse_detector
  import key_pulse_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  input  logic [1:0]        mode,
  output logic [N_KEYS-1:0] level,
  output logic [N_KEYS-1:0] pulse,
  output logic              any_pulse
);

  pulse_mode_e mode_e;
  logic        any_pulse_q;

  assign mode_e = pulse_mode_e'(mode);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_pulse_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .key  (key[g]),
      .mode (mode_e),
      .level(level[g]),
      .pulse(pulse[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_pulse_q <= 1'b0;
    end else begin
      any_pulse_q <= |pulse;
    end
  end

  assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_key_pulse_detector.sv
// tb/tb_key_pulse_detector.sv - self-checking bench: directed table, corner sequences, random vs model
module tb_key_pulse_detector;

  localparam int N = 4;
  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] key;
  logic [1:0]   mode;
  logic [N-1:0] level;
  logic [N-1:0] pulse;
  logic         any_pulse;

  always #5 clk = ~clk;

  key_pulse_detector #(
    .N_KEYS         (N),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key),
    .mode     (mode),
    .level    (level),
    .pulse    (pulse),
    .any_pulse(any_pulse)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model: state after the most recent edge
  logic [N-1:0] m_s1, m_s2, m_st, m_st_prev, m_pulse;
  logic         m_any;
  int           run_len   [N];
  logic         run_val   [N];
  int           anchor    [N];
  bit           anchor_ok [N];

  typedef struct {
    logic [N-1:0] key;
    logic [1:0]   mode;
    int           ncyc;
    logic [N-1:0] exp_level;
    int           exp_pulses;
    int           exp_any;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_st = '0; m_st_prev = '0; m_pulse = '0; m_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      run_len[i] = 0; run_val[i] = 1'b0; anchor[i] = 0; anchor_ok[i] = 1'b0;
    end
  endtask

  // level accepted once the last D synchronised samples all agree on a new value;
  // repeats fall on anchor+H+k*R while the key stays down in repeat mode
  task automatic model_step();
    logic [N-1:0] np;
    logic         new_st, rise, fall, rep;
    np = '0;
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] == run_val[i]) run_len[i]++;
      else begin run_val[i] = m_s2[i]; run_len[i] = 1; end
      new_st = (run_len[i] >= D && run_val[i] != m_st[i]) ? run_val[i] : m_st[i];
      rise = m_st[i] & ~m_st_prev[i];
      fall = ~m_st[i] & m_st_prev[i];
      rep  = 1'b0;
      if (anchor_ok[i]) begin
        if (!m_st[i] || mode != 2'd3) anchor_ok[i] = 1'b0;
        else if (cyc - anchor[i] >= H && (cyc - anchor[i] - H) % R == 0) rep = 1'b1;
      end
      if (rise && mode == 2'd3) begin
        anchor_ok[i] = 1'b1;
        anchor[i]    = cyc;
      end
      np[i] = (rise && mode != 2'd1) || (fall && (mode == 2'd1 || mode == 2'd2)) || rep;
      m_st_prev[i] = m_st[i];
      m_st[i]      = new_st;
    end
    m_any   = |m_pulse;
    m_pulse = np;
    m_s2    = m_s1;
    m_s1    = key;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check("level", level, m_st);
    check("pulse", pulse, m_pulse);
    check("any_pulse", any_pulse, m_any);
  endtask

  initial begin
    int np, na, p_at;
    bit found;

    tbl[0] = '{4'b0001, 2'd0, 20, 4'b0001, 1, 1};
    tbl[1] = '{4'b0000, 2'd0, 20, 4'b0000, 0, 0};
    tbl[2] = '{4'b0100, 2'd2, 20, 4'b0100, 1, 1};
    tbl[3] = '{4'b0000, 2'd2, 20, 4'b0000, 1, 1};
    tbl[4] = '{4'b0100, 2'd1, 20, 4'b0100, 0, 0};
    tbl[5] = '{4'b0000, 2'd1, 20, 4'b0000, 1, 1};
    tbl[6] = '{4'b1111, 2'd0, 20, 4'b1111, 4, 1};
    tbl[7] = '{4'b0000, 2'd0, 20, 4'b0000, 0, 0};
    tbl[8] = '{4'b0010, 2'd2, 3,  4'b0000, 0, 0};
    tbl[9] = '{4'b0000, 2'd2, 10, 4'b0000, 0, 0};

    rst_n = 1'b1; key = '0; mode = 2'd0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset_level", level, 0);
    check("reset_pulse", pulse, 0);
    check("reset_any", any_pulse, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // latency from capture edge k: level at k+5, pulse at k+6, any_pulse at k+7
    key = 4'b0001;
    for (int j = 0; j <= 8; j++) begin
      tick();
      check("lat_level", level[0], (j >= D + 1) ? 1 : 0);
      check("lat_pulse", pulse[0], (j == D + 2) ? 1 : 0);
      check("lat_any", any_pulse, (j == D + 3) ? 1 : 0);
    end
    key = '0;
    repeat (15) tick();

    foreach (tbl[v]) begin
      key = tbl[v].key; mode = tbl[v].mode;
      np = 0; na = 0;
      for (int c = 0; c < tbl[v].ncyc; c++) begin
        tick();
        np += $countones(pulse);
        na += int'(any_pulse);
      end
      check("tbl_level", level, tbl[v].exp_level);
      check("tbl_pulses", np, tbl[v].exp_pulses);
      check("tbl_any", na, tbl[v].exp_any);
    end

    // hold-repeat: pulses at P, P+10, P+15, ..., P+30
    mode = 2'd3; key = 4'b0001;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (pulse[0]) found = 1'b1;
    end
    check("rep_first_pulse", found, 1);
    for (int t = 1; t <= 30; t++) begin
      tick();
      check("rep_train", pulse[0], (t >= H && (t - H) % R == 0) ? 1 : 0);
    end
    key = '0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (!level[0]) found = 1'b1;
    end
    check("rep_release", found, 1);
    np = 0;
    repeat (30) begin tick(); np += int'(pulse[0]); end
    check("rep_after_release", np, 0);

    // reset in the middle of a repeat train, key kept down through release
    key = 4'b0001;
    repeat (30) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrep_level", level, 0);
    check("midrep_pulse", pulse, 0);
    check("midrep_any", any_pulse, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    p_at = 0;
    for (int j = 1; j <= 9; j++) begin
      tick();
      check("rst_rise_pulse", pulse[0], (j == D + 3) ? 1 : 0);
    end
    mode = 2'd0; key = '0;
    repeat (20) tick();

    // random stimulus, mostly slow keys with occasional glitches
    for (int c = 0; c < 5000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) key[i] = ~key[i];
      if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1999) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rand_reset_pulse", pulse, 0);
        repeat (2) tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
